// File: rtl/latency_ping_pkg.sv
// -----------------------------------------------------------------------------
// latency_ping_pkg
//   Shared definitions for the link-latency ping scheduler: the scheduler
//   state encoding, the 8b/10b control characters it recognises and emits,
//   the width of the statistics counters and a saturating increment helper.
// -----------------------------------------------------------------------------
package latency_ping_pkg;

   // Scheduler states: waiting out the ping interval, waiting for an idle
   // slot to replace, and waiting for the far end to echo the marker.
   typedef enum logic [1:0] {
      WAIT_INTERVAL = 2'd0,
      WAIT_SLOT     = 2'd1,
      WAIT_ECHO     = 2'd2
   } ping_state_t;

   // Idle comma that may be replaced, and the default marker character.
   localparam logic [7:0] K28_5 = 8'hBC;
   localparam logic [7:0] K28_2 = 8'h5C;

   // Width of the marker and timeout statistics counters.
   localparam int STAT_WIDTH = 16;

   // Increment that sticks at all-ones instead of wrapping to zero.
   function automatic logic [STAT_WIDTH-1:0] satInc(input logic [STAT_WIDTH-1:0] value);
      if (value == {STAT_WIDTH{1'b1}}) begin
         return value;
      end
      return value + STAT_WIDTH'(1);
   endfunction

endpackage

// File: rtl/sync_toggle_edge.sv
// -----------------------------------------------------------------------------
// sync_toggle_edge
//   Brings an asynchronous level or toggle signal into the local clock domain
//   through a two-flop synchroniser, and flags any change of the synchronised
//   level for one clock.
//
// Ports
//   i_clk    in  1  destination clock
//   i_rst_n  in  1  asynchronous, active-low reset
//   i_async  in  1  asynchronous input
//   o_sync   out 1  synchronised level
//   o_edge   out 1  high for one clock after the synchronised level changes
// -----------------------------------------------------------------------------
module sync_toggle_edge (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_async,
   output logic o_sync,
   output logic o_edge
);

   logic r_meta;
   logic r_sync;
   logic r_prev;

   // Two synchroniser stages followed by one history stage; the history
   // stage lets a toggle be seen as a single-cycle pulse whichever way it goes.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
         r_prev <= 1'b0;
      end else begin
         r_meta <= i_async;
         r_sync <= r_meta;
         r_prev <= r_sync;
      end
   end

   assign o_sync = r_sync;
   assign o_edge = r_sync ^ r_prev;

endmodule

// File: rtl/latency_ping_scheduler.sv
// -----------------------------------------------------------------------------
// latency_ping_scheduler
//   Upstream half of the link-latency measurement, clocked by the transceiver
//   TX user clock. Every INTERVAL_TICKS clocks it arms, replaces the next idle
//   K28.5 in the low TX byte with MARKER and toggles 'ping' in the very cycle
//   the marker is on txDataOut. It then waits for the echo toggle (or
//   TIMEOUT_TICKS clocks) before it may arm again.
//
// Build option
//   LATENCY_PING_STATS_EN  when defined, pingCount/timeoutCount count markers
//                          sent and echo timeouts (saturating). When not
//                          defined both outputs are tied to zero. Scheduling,
//                          ping and the TX path do not depend on it.
//
// Parameters
//   INTERVAL_TICKS  clocks between marker emissions
//   TIMEOUT_TICKS   clocks to wait for an echo after a marker
//   MARKER          K character put in place of the idle
//
// Ports
//   sysClk        in  1   TX user clock
//   sysReset_n    in  1   asynchronous, active-low reset
//   enable        in  1   static control; low = passthrough, no pings
//   rxValid       in  1   async; receive side aligned
//   echo          in  1   async toggle; each change = echo received
//   txDataIn      in  16  TX data from the framer
//   txCharIsKIn   in  2   K flags for txDataIn
//   txDataOut     out 16  TX data to the transceiver (1 clock latency)
//   txCharIsKOut  out 2   K flags to the transceiver
//   ping          out 1   toggles in the cycle the marker is on txDataOut
//   busy          out 1   high while waiting for a slot or for the echo
//   pingCount     out 16  markers sent, saturating
//   timeoutCount  out 16  echo timeouts, saturating
// -----------------------------------------------------------------------------
module latency_ping_scheduler
   import latency_ping_pkg::*;
#(
   parameter int unsigned INTERVAL_TICKS = 125000,
   parameter int unsigned TIMEOUT_TICKS  = 500,
   parameter logic [7:0]  MARKER         = K28_2
) (
   input  logic                  sysClk,
   input  logic                  sysReset_n,
   input  logic                  enable,
   input  logic                  rxValid,
   input  logic                  echo,
   input  logic [15:0]           txDataIn,
   input  logic [1:0]            txCharIsKIn,
   output logic [15:0]           txDataOut,
   output logic [1:0]            txCharIsKOut,
   output logic                  ping,
   output logic                  busy,
   output logic [STAT_WIDTH-1:0] pingCount,
   output logic [STAT_WIDTH-1:0] timeoutCount
);

   localparam int IW = ($clog2(INTERVAL_TICKS) < 1) ? 1 : $clog2(INTERVAL_TICKS);
   localparam int TW = ($clog2(TIMEOUT_TICKS) < 1) ? 1 : $clog2(TIMEOUT_TICKS);

   localparam logic [IW-1:0] INTERVAL_RELOAD = IW'(INTERVAL_TICKS - 1);
   localparam logic [TW-1:0] TIMEOUT_RELOAD  = TW'(TIMEOUT_TICKS - 1);

   ping_state_t   r_state;
   logic [IW-1:0] r_intervalTimer;
   logic [TW-1:0] r_echoTimer;
   logic          r_ping;
   logic          r_busy;
   logic [15:0]   r_txData;
   logic [1:0]    r_txCharIsK;

   logic w_rxValidSync;
   logic w_rxValidEdgeUnused;
   logic w_echoLevelUnused;
   logic w_echoEdge;
   logic w_slot;
   logic w_linkUp;
   logic w_emit;
   logic w_echoExpired;

   // rxValid only needs its level; its change pulse is left unused.
   sync_toggle_edge u_rxValidSync (
      .i_clk   (sysClk),
      .i_rst_n (sysReset_n),
      .i_async (rxValid),
      .o_sync  (w_rxValidSync),
      .o_edge  (w_rxValidEdgeUnused)
   );

   // echo is a toggle, so only its change pulse matters.
   sync_toggle_edge u_echoSync (
      .i_clk   (sysClk),
      .i_rst_n (sysReset_n),
      .i_async (echo),
      .o_sync  (w_echoLevelUnused),
      .o_edge  (w_echoEdge)
   );

   // A slot is an idle comma in the low byte; the high byte is never touched.
   // The marker is only inserted while the link is usable, so dropping enable
   // or rxValid lets a slot in that same cycle through unmodified.
   assign w_slot        = txCharIsKIn[0] && (txDataIn[7:0] == K28_5);
   assign w_linkUp      = enable && w_rxValidSync;
   assign w_emit        = w_linkUp && (r_state == WAIT_SLOT) && w_slot;
   // An echo arriving in the expiry cycle takes priority over the timeout.
   assign w_echoExpired = w_linkUp && (r_state == WAIT_ECHO) && !w_echoEdge
                          && (r_echoTimer == '0);

   // Scheduler FSM together with its registered outputs. The TX path is a
   // single register stage so the marker and the ping toggle leave together.
   // The interval timer free-runs down to zero in every state; if it already
   // hit zero while waiting for an echo, the next WAIT_INTERVAL cycle arms
   // straight away.
   always_ff @(posedge sysClk or negedge sysReset_n) begin
      if (!sysReset_n) begin
         r_state         <= WAIT_INTERVAL;
         r_intervalTimer <= INTERVAL_RELOAD;
         r_echoTimer     <= '0;
         r_ping          <= 1'b0;
         r_busy          <= 1'b0;
         r_txData        <= '0;
         r_txCharIsK     <= '0;
      end else begin
         r_txData    <= {txDataIn[15:8], (w_emit ? MARKER : txDataIn[7:0])};
         r_txCharIsK <= {txCharIsKIn[1], (txCharIsKIn[0] | w_emit)};

         if (r_intervalTimer != '0) begin
            r_intervalTimer <= r_intervalTimer - IW'(1);
         end

         if (!w_linkUp) begin
            r_state         <= WAIT_INTERVAL;
            r_intervalTimer <= INTERVAL_RELOAD;
            r_busy          <= 1'b0;
         end else begin
            case (r_state)
               WAIT_INTERVAL: begin
                  if (r_intervalTimer == '0) begin
                     r_state <= WAIT_SLOT;
                     r_busy  <= 1'b1;
                  end
               end
               WAIT_SLOT: begin
                  if (w_emit) begin
                     r_ping          <= ~r_ping;
                     r_intervalTimer <= INTERVAL_RELOAD;
                     r_echoTimer     <= TIMEOUT_RELOAD;
                     r_state         <= WAIT_ECHO;
                  end
               end
               WAIT_ECHO: begin
                  if (w_echoEdge || w_echoExpired) begin
                     r_state <= WAIT_INTERVAL;
                     r_busy  <= 1'b0;
                  end else begin
                     r_echoTimer <= r_echoTimer - TW'(1);
                  end
               end
               default: begin
                  r_state <= WAIT_INTERVAL;
                  r_busy  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign txDataOut    = r_txData;
   assign txCharIsKOut = r_txCharIsK;
   assign ping         = r_ping;
   assign busy         = r_busy;

`ifdef LATENCY_PING_STATS_EN
   logic [STAT_WIDTH-1:0] r_pingCount;
   logic [STAT_WIDTH-1:0] r_timeoutCount;

   // Marker and timeout statistics; both stick at full scale.
   always_ff @(posedge sysClk or negedge sysReset_n) begin
      if (!sysReset_n) begin
         r_pingCount    <= '0;
         r_timeoutCount <= '0;
      end else begin
         if (w_emit) begin
            r_pingCount <= satInc(r_pingCount);
         end
         if (w_echoExpired) begin
            r_timeoutCount <= satInc(r_timeoutCount);
         end
      end
   end

   assign pingCount    = r_pingCount;
   assign timeoutCount = r_timeoutCount;
`else
   assign pingCount    = '0;
   assign timeoutCount = '0;
`endif

endmodule

// File: tb/tb_latency_ping_scheduler.sv
// -----------------------------------------------------------------------------
// tb_latency_ping_scheduler
//   Self-checking bench for latency_ping_scheduler with INTERVAL_TICKS=20 and
//   TIMEOUT_TICKS=8. A timestamp-based reference model tracks when the
//   interval elapsed, when the marker left and which echo toggles were seen,
//   and every cycle of every scenario is compared against it.
// -----------------------------------------------------------------------------
module tb_latency_ping_scheduler;

   localparam int INTERVAL = 20;
   localparam int TIMEOUT  = 8;
`ifdef LATENCY_PING_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic        sysClk = 1'b0;
   logic        sysReset_n;
   logic        enable;
   logic        rxValid;
   logic        echo;
   logic [15:0] txDataIn;
   logic [1:0]  txCharIsKIn;
   logic [15:0] txDataOut;
   logic [1:0]  txCharIsKOut;
   logic        ping;
   logic        busy;
   logic [15:0] pingCount;
   logic [15:0] timeoutCount;

   int assertCount = 0;
   int failCount   = 0;

   latency_ping_scheduler #(
      .INTERVAL_TICKS (INTERVAL),
      .TIMEOUT_TICKS  (TIMEOUT),
      .MARKER         (8'h5C)
   ) dut (
      .sysClk       (sysClk),
      .sysReset_n   (sysReset_n),
      .enable       (enable),
      .rxValid      (rxValid),
      .echo         (echo),
      .txDataIn     (txDataIn),
      .txCharIsKIn  (txCharIsKIn),
      .txDataOut    (txDataOut),
      .txCharIsKOut (txCharIsKOut),
      .ping         (ping),
      .busy         (busy),
      .pingCount    (pingCount),
      .timeoutCount (timeoutCount)
   );

   always #5 sysClk = ~sysClk;

   // Reference model. Time is counted in clock edges; the interval is over
   // once INTERVAL edges have passed since the last reload, the echo wait is
   // over TIMEOUT edges after the marker. The async inputs are seen two edges
   // late, and an echo is a difference between consecutive late samples.
   int          mEdge = 0;
   int          mReloadEdge;
   int          mMarkerEdge;
   bit          mArmed;
   bit          mAwait;
   bit          mPing;
   logic [15:0] mPings;
   logic [15:0] mTimeouts;
   bit          mRx1, mRx2, mE1, mE2, mE3;
   logic [15:0] mData;
   logic [1:0]  mK;

   always @(posedge sysClk or negedge sysReset_n) begin
      if (!sysReset_n) begin
         mReloadEdge = mEdge;
         mMarkerEdge = mEdge;
         mArmed = 0; mAwait = 0; mPing = 0;
         mPings = 16'h0; mTimeouts = 16'h0;
         mRx1 = 0; mRx2 = 0; mE1 = 0; mE2 = 0; mE3 = 0;
         mData = 16'h0; mK = 2'b00;
      end else begin : modelStep
         bit live;
         bit slot;
         bit echoSeen;
         bit fire;
         mEdge++;
         live     = enable && mRx2;
         slot     = txCharIsKIn[0] && (txDataIn[7:0] == 8'hBC);
         echoSeen = mE2 ^ mE3;
         fire     = 0;
         if (!live) begin
            mArmed = 0; mAwait = 0; mReloadEdge = mEdge;
         end else if (mAwait) begin
            if (echoSeen) mAwait = 0;
            else if (mEdge - mMarkerEdge >= TIMEOUT) begin
               mAwait = 0;
               if (mTimeouts != 16'hFFFF) mTimeouts = mTimeouts + 16'd1;
            end
         end else if (mArmed) begin
            fire = slot;
         end else if (mEdge - mReloadEdge >= INTERVAL) begin
            mArmed = 1;
         end
         if (fire) begin
            mArmed = 0; mAwait = 1; mPing = !mPing;
            mReloadEdge = mEdge; mMarkerEdge = mEdge;
            if (mPings != 16'hFFFF) mPings = mPings + 16'd1;
         end
         mData = {txDataIn[15:8], (fire ? 8'h5C : txDataIn[7:0])};
         mK    = {txCharIsKIn[1], (txCharIsKIn[0] | fire)};
         mRx2 = mRx1; mRx1 = rxValid;
         mE3 = mE2; mE2 = mE1; mE1 = echo;
      end
   end

   wire [51:0] obsVec = {txDataOut, txCharIsKOut, ping, busy, pingCount, timeoutCount};
   wire [51:0] expVec = {mData, mK, mPing, (mArmed | mAwait),
                         (STATS ? mPings : 16'h0), (STATS ? mTimeouts : 16'h0)};

   // Drives one cycle of TX data: an idle comma in the low byte, or traffic
   // that is guaranteed not to look like one.
   task automatic applyStimulus(input bit idle);
      logic [15:0] d;
      logic [1:0]  k;
      d = 16'($urandom);
      k = 2'($urandom);
      if (idle) begin
         d[7:0] = 8'hBC;
         k[0]   = 1'b1;
      end else if (k[0] && d[7:0] == 8'hBC) begin
         k[0] = 1'b0;
      end
      txDataIn    = d;
      txCharIsKIn = k;
   endtask

   task automatic doReset();
      sysReset_n = 1'b0;
      enable = 1'b0; rxValid = 1'b0; echo = 1'b0;
      applyStimulus(1'b0);
      repeat (3) @(negedge sysClk);
      sysReset_n = 1'b1;
      enable = 1'b1; rxValid = 1'b1;
   endtask

   task automatic test_reset();
      logic [15:0] sent;
      sysReset_n = 1'b0;
      enable = 1'b1; rxValid = 1'b1; echo = 1'b0;
      applyStimulus(1'b1);
      repeat (2) @(negedge sysClk);
      assertCount++;
      if (txDataOut !== 16'h0) begin failCount++; $display("[TB] FAIL reset_txData: got %h, expected 0000", txDataOut); end
      assertCount++;
      if (txCharIsKOut !== 2'b00) begin failCount++; $display("[TB] FAIL reset_txK: got %b, expected 00", txCharIsKOut); end
      assertCount++;
      if (ping !== 1'b0) begin failCount++; $display("[TB] FAIL reset_ping: got %b, expected 0", ping); end
      assertCount++;
      if (busy !== 1'b0) begin failCount++; $display("[TB] FAIL reset_busy: got %b, expected 0", busy); end
      assertCount++;
      if (pingCount !== 16'h0) begin failCount++; $display("[TB] FAIL reset_pingCount: got %0d, expected 0", pingCount); end
      assertCount++;
      if (timeoutCount !== 16'h0) begin failCount++; $display("[TB] FAIL reset_timeoutCount: got %0d, expected 0", timeoutCount); end
      sysReset_n = 1'b1;
      applyStimulus(1'b0);
      sent = txDataIn;
      @(negedge sysClk);
      assertCount++;
      if (txDataOut !== sent) begin failCount++; $display("[TB] FAIL first_passthrough: got %h, expected %h", txDataOut, sent); end
   endtask

   task automatic test_idle_echo();
      int toggles = 0;
      int countdown = 0;
      int cycles = 0;
      logic lastPing;
      doReset();
      lastPing = ping;
      while (toggles < 3 && cycles < 200) begin
         applyStimulus(1'b1);
         @(negedge sysClk);
         cycles++;
         assertCount++;
         if (obsVec !== expVec) begin failCount++; $display("[TB] FAIL idle_echo cycle %0d: got %h, expected %h", cycles, obsVec, expVec); end
         if (countdown > 0) begin
            countdown--;
            if (countdown == 0) echo = ~echo;
         end
         if (ping !== lastPing) begin
            lastPing = ping;
            toggles++;
            countdown = $urandom_range(4, 1);
            assertCount++;
            if ({txCharIsKOut[0], txDataOut[7:0]} !== 9'h15C) begin
               failCount++; $display("[TB] FAIL marker_with_ping: got K=%b data=%h, expected K=1 data=5c", txCharIsKOut[0], txDataOut[7:0]);
            end
         end
      end
      assertCount++;
      if (toggles != 3) begin failCount++; $display("[TB] FAIL idle_echo_budget: got %0d pings, expected 3", toggles); end
      assertCount++;
      if (pingCount !== (STATS ? 16'd3 : 16'd0)) begin failCount++; $display("[TB] FAIL idle_echo_pingCount: got %0d, expected %0d", pingCount, STATS ? 3 : 0); end
      assertCount++;
      if (timeoutCount !== 16'd0) begin failCount++; $display("[TB] FAIL idle_echo_timeoutCount: got %0d, expected 0", timeoutCount); end
   endtask

   task automatic test_timeout();
      int toggles = 0;
      int after = 0;
      int cycles = 0;
      logic lastPing;
      doReset();
      lastPing = ping;
      while (after < 9 && cycles < 300) begin
         applyStimulus(1'b1);
         @(negedge sysClk);
         cycles++;
         assertCount++;
         if (obsVec !== expVec) begin failCount++; $display("[TB] FAIL timeout cycle %0d: got %h, expected %h", cycles, obsVec, expVec); end
         if (toggles == 4) after++;
         if (ping !== lastPing) begin
            lastPing = ping;
            toggles++;
         end
      end
      assertCount++;
      if (toggles != 4) begin failCount++; $display("[TB] FAIL timeout_budget: got %0d pings, expected 4", toggles); end
      assertCount++;
      if (timeoutCount !== (STATS ? 16'd4 : 16'd0)) begin failCount++; $display("[TB] FAIL timeout_count: got %0d, expected %0d", timeoutCount, STATS ? 4 : 0); end
   endtask

   task automatic test_traffic();
      int cycles = 0;
      bit toggled = 0;
      doReset();
      while (busy !== 1'b1 && cycles < 60) begin
         applyStimulus(1'b0);
         @(negedge sysClk);
         cycles++;
         assertCount++;
         if (obsVec !== expVec) begin failCount++; $display("[TB] FAIL traffic_arm cycle %0d: got %h, expected %h", cycles, obsVec, expVec); end
      end
      for (int i = 0; i < 50; i++) begin
         applyStimulus(1'b0);
         @(negedge sysClk);
         assertCount++;
         if (obsVec !== expVec) begin failCount++; $display("[TB] FAIL traffic_hold cycle %0d: got %h, expected %h", i, obsVec, expVec); end
      end
      assertCount++;
      if ({busy, ping} !== 2'b10) begin failCount++; $display("[TB] FAIL traffic_stall: got busy=%b ping=%b, expected busy=1 ping=0", busy, ping); end
      for (int i = 0; i < 4 && !toggled; i++) begin
         applyStimulus(1'b1);
         @(negedge sysClk);
         assertCount++;
         if (obsVec !== expVec) begin failCount++; $display("[TB] FAIL traffic_release cycle %0d: got %h, expected %h", i, obsVec, expVec); end
         toggled = (ping === 1'b1);
      end
      assertCount++;
      if (!toggled || txDataOut[7:0] !== 8'h5C) begin failCount++; $display("[TB] FAIL traffic_first_idle: got ping=%b data=%h, expected ping=1 data=5c", ping, txDataOut[7:0]); end
   endtask

   task automatic test_coincide();
      int toggles = 0;
      int countdown = 0;
      int since = -1;
      int cycles = 0;
      logic lastPing;
      doReset();
      lastPing = ping;
      while (!(toggles == 2 && since == 10) && cycles < 200) begin
         applyStimulus(1'b1);
         @(negedge sysClk);
         cycles++;
         assertCount++;
         if (obsVec !== expVec) begin failCount++; $display("[TB] FAIL coincide cycle %0d: got %h, expected %h", cycles, obsVec, expVec); end
         if (countdown > 0) begin
            countdown--;
            if (countdown == 0) echo = ~echo;
         end
         if (since >= 0) since++;
         if (toggles == 1 && since == 9) begin
            assertCount++;
            if ({busy, timeoutCount} !== 17'h0) begin failCount++; $display("[TB] FAIL coincide_echo_wins: got busy=%b timeoutCount=%0d, expected 0 and 0", busy, timeoutCount); end
         end
         if (ping !== lastPing) begin
            lastPing = ping;
            toggles++;
            since = 0;
            countdown = (toggles == 1) ? 5 : 6;
         end
      end
      assertCount++;
      if (timeoutCount !== (STATS ? 16'd1 : 16'd0)) begin failCount++; $display("[TB] FAIL late_echo_timeout: got %0d, expected %0d", timeoutCount, STATS ? 1 : 0); end
   endtask

   task automatic test_drop_and_reset();
      int cycles = 0;
      bit toggled = 0;
      doReset();
      for (int pass = 0; pass < 2; pass++) begin
         cycles = 0;
         while (busy !== 1'b1 && cycles < 60) begin
            applyStimulus(1'b0);
            @(negedge sysClk);
            cycles++;
            assertCount++;
            if (obsVec !== expVec) begin failCount++; $display("[TB] FAIL drop_arm pass %0d: got %h, expected %h", pass, obsVec, expVec); end
         end
         if (pass == 0) enable = 1'b0;
         else rxValid = 1'b0;
         for (int i = 0; i < 8; i++) begin
            applyStimulus(i >= 3);
            @(negedge sysClk);
            assertCount++;
            if (obsVec !== expVec) begin failCount++; $display("[TB] FAIL drop pass %0d cycle %0d: got %h, expected %h", pass, i, obsVec, expVec); end
         end
         assertCount++;
         if ({ping, busy, txDataOut[7:0]} !== 10'h0BC) begin failCount++; $display("[TB] FAIL drop_no_marker pass %0d: got ping=%b busy=%b data=%h, expected 0 0 bc", pass, ping, busy, txDataOut[7:0]); end
         enable = 1'b1; rxValid = 1'b1;
      end
      cycles = 0;
      while (!toggled && cycles < 60) begin
         applyStimulus(1'b1);
         @(negedge sysClk);
         cycles++;
         assertCount++;
         if (obsVec !== expVec) begin failCount++; $display("[TB] FAIL pre_reset cycle %0d: got %h, expected %h", cycles, obsVec, expVec); end
         toggled = (ping === 1'b1);
      end
      repeat (2) @(negedge sysClk);
      #2 sysReset_n = 1'b0;
      #1;
      assertCount++;
      if (obsVec !== 52'h0) begin failCount++; $display("[TB] FAIL async_reset: got %h, expected all zero", obsVec); end
      @(negedge sysClk);
      sysReset_n = 1'b1;
      toggled = 0;
      cycles = 0;
      while (!toggled && cycles < 60) begin
         applyStimulus(1'b1);
         @(negedge sysClk);
         cycles++;
         assertCount++;
         if (obsVec !== expVec) begin failCount++; $display("[TB] FAIL post_reset cycle %0d: got %h, expected %h", cycles, obsVec, expVec); end
         toggled = (ping === 1'b1);
      end
      assertCount++;
      if (!toggled) begin failCount++; $display("[TB] FAIL post_reset_ping: got no ping in %0d cycles, expected one", cycles); end
   endtask

   task automatic test_random();
      doReset();
      for (int i = 0; i < 600; i++) begin
         applyStimulus($urandom_range(1, 0) == 1);
         if ($urandom_range(40, 0) == 0) enable = ~enable;
         else if (!enable && $urandom_range(4, 0) == 0) enable = 1'b1;
         if ($urandom_range(60, 0) == 0) rxValid = ~rxValid;
         else if (!rxValid && $urandom_range(4, 0) == 0) rxValid = 1'b1;
         if ($urandom_range(10, 0) == 0) echo = ~echo;
         @(negedge sysClk);
         assertCount++;
         if (obsVec !== expVec) begin failCount++; $display("[TB] FAIL random cycle %0d: got %h, expected %h", i, obsVec, expVec); end
      end
   endtask

   initial begin
      sysReset_n = 1'b0;
      enable = 1'b0; rxValid = 1'b0; echo = 1'b0;
      txDataIn = 16'h0; txCharIsKIn = 2'b00;
      @(negedge sysClk);
      test_reset();
      test_idle_echo();
      test_timeout();
      test_traffic();
      test_coincide();
      test_drop_and_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
